alu_sched: RTL and testbench
============================

# alu_sched

Scheduler that shares the team's single 16-bit, 8-function combinational ALU between two requesters. It accepts one operation at a time through valid/ready handshakes and arbitrates round-robin when both requesters are valid. It drives and holds the ALU operands, captures the result, and returns it through a tagged response handshake. It sits between the two issuing blocks and the ALU instance, which is external and wired to the alu_* ports.

## Interface
- WIDTH, 16, operand/result width; all arithmetic is modulo 2^WIDTH.
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state on the clock edge where it is high.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_op  in  3  ALU function code: 000 add, 001 sub, 010 and, 011 xor, 100 or, 101 x+1, 110 x<<1, 111 x>>1.
- req0_x, req0_y  in  WIDTH  operands.
- req0_ready  out  1  scheduler accepts requester 0 this cycle.
- req1_valid, req1_op, req1_x, req1_y, req1_ready  same meaning for requester 1.
- rsp_valid  out  1  result available.
- rsp_id  out  1  owner of the result (0/1).
- rsp_data  out  WIDTH  registered ALU result.
- rsp_ready  in  1  owner consumes the result.
- alu_op  out  3  function code to the ALU.
- alu_x, alu_y  out  WIDTH  operands to the ALU.
- alu_ans  in  WIDTH  ALU result; combinational function of alu_op/alu_x/alu_y.
- busy  out  1  state != IDLE.
- ops_done  out  16  completed-operation count; wraps 0xFFFF→0x0000.

## Operation
- States: IDLE, DRIVE, CAPTURE, RESP.
- IDLE:
  - req0_ready = ~reset & valid0 & (~valid1 | last_grant==1).
  - req1_ready = ~reset & valid1 & (~valid0 | last_grant==0).
  - At most one ready is high per cycle.
  - On an accept, latch op/x/y and owner, set alu_op/alu_x/alu_y from the latched values, and go to DRIVE.
- DRIVE: no action; ALU settle cycle. Go to CAPTURE.
- CAPTURE: register alu_ans into rsp_data, set rsp_valid=1 and rsp_id=owner. Go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id and rsp_data stable until rsp_ready.
  - On rsp_valid & rsp_ready: clear rsp_valid, set last_grant=owner, increment ops_done, go to IDLE.
- alu_op/alu_x/alu_y stay constant from the edge after accept until the next accept, including through IDLE.
- Both ready outputs are 0 in every state other than IDLE. A request arriving while busy waits; requesters must hold valid and payload until ready.
- Arbitration:
  - last_grant resets to 1, so requester 0 wins the first contention.
  - Under continuous contention, grants alternate 0,1,0,1.
  - A lone valid requester is always granted, regardless of last_grant.
- Result semantics come from the external ALU: sub wraps (0x0000-0x0001 = 0xFFFF), x+1 wraps (0xFFFF→0x0000), shifts are logical with zero fill, and y is ignored for codes 101–111.
- rsp_ready while rsp_valid=0 has no effect.
- Reset, including mid-operation:
  - In-flight operation is discarded; state=IDLE.
  - rsp_valid=0, rsp_id=0, rsp_data=0.
  - alu_op=0, alu_x=0, alu_y=0.
  - busy=0, ops_done=0, last_grant=1.
  - Both ready outputs are 0 while reset is high.

## Timing
- Accept at the edge ending cycle T. DRIVE in T+1, CAPTURE in T+2, rsp_valid=1 from T+3.
- Earliest next accept is cycle T+4, when rsp_ready=1 in T+3. Peak throughput is one operation per 4 cycles.
- ALU path budget: one full cycle (DRIVE) plus the CAPTURE cycle. rsp_data is a flop output.
- Each additional cycle of rsp_ready=0 in RESP adds one cycle of latency.
- ops_done and last_grant update on the response-handshake edge.

## Test plan
- Reset, then hold all inputs 0 → all outputs 0, busy=0, ops_done=0 for 10 cycles.
- req0 only, op=000, x=0x1234, y=0x0F0F, rsp_ready=1 → req0_ready in cycle T, rsp_valid=1 with rsp_id=0 and rsp_data=0x2143 in T+3; next accept in T+4; ops_done=1.
- Both requesters valid continuously: req0 op=001 with x=0, y=1; req1 op=101 with x=0xFFFF → grants alternate 0,1,0,1; responses 0xFFFF (id 0) and 0x0000 (id 1); requester 0 is granted first after reset.
- Response stall: req1 op=110, x=0x8001; hold rsp_ready=0 for 5 cycles → rsp_data=0x0002 stays stable, busy=1, both ready outputs 0 despite a pending req0; the accept of req0 follows the handshake.
- Sweep all 8 codes with x=0xA5A5, y=0x0FF0 → 0xB595, 0x95B5, 0x05A0, 0xAA55, 0xAFF5, 0xA5A6, 0x4B4A, 0x52D2.
- Assert reset in the CAPTURE cycle, then release with req1 valid → rsp_valid never rises for the aborted operation, ops_done=0, and requester 1 is accepted in the first post-reset cycle.

Source files
------------

// File: rtl/alu_sched.sv
// Scheduler sharing one external combinational ALU between two requesters.
// Round-robin accept, fixed DRIVE/CAPTURE settle window, tagged response handshake.
module alu_sched #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic [2:0]       req0_op,
   input  logic [WIDTH-1:0] req0_x,
   input  logic [WIDTH-1:0] req0_y,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [2:0]       req1_op,
   input  logic [WIDTH-1:0] req1_x,
   input  logic [WIDTH-1:0] req1_y,
   output logic             req1_ready,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   input  logic             rsp_ready,
   output logic [2:0]       alu_op,
   output logic [WIDTH-1:0] alu_x,
   output logic [WIDTH-1:0] alu_y,
   input  logic [WIDTH-1:0] alu_ans,
   output logic             busy,
   output logic [15:0]      ops_done
);

   localparam int unsigned OP_W  = 3;
   localparam int unsigned CNT_W = 16;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_DRIVE   = 2'd1,
      S_CAPTURE = 2'd2,
      S_RESP    = 2'd3
   } state_e;

   state_e             state_q, state_d;

   logic               owner_q, owner_d;
   logic               last_grant_q, last_grant_d;
   logic [OP_W-1:0]    alu_op_q, alu_op_d;
   logic [WIDTH-1:0]   alu_x_q, alu_x_d;
   logic [WIDTH-1:0]   alu_y_q, alu_y_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic               rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
   logic [CNT_W-1:0]   ops_done_q, ops_done_d;

   logic               accept_c;
   logic               rsp_fire_c;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (accept_c)   state_d = S_DRIVE;
         S_DRIVE:                   state_d = S_CAPTURE;
         S_CAPTURE:                 state_d = S_RESP;
         S_RESP:    if (rsp_fire_c) state_d = S_IDLE;
         default:                   state_d = S_IDLE;
      endcase
   end

   // Handshake outputs; last_grant breaks ties so contention alternates
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (state_q == S_IDLE && !reset) begin
         req0_ready = req0_valid & (~req1_valid |  last_grant_q);
         req1_ready = req1_valid & (~req0_valid | ~last_grant_q);
      end
   end

   assign accept_c   = req0_ready | req1_ready;
   assign rsp_fire_c = (state_q == S_RESP) & rsp_valid_q & rsp_ready;

   // Datapath next values: ALU operands held from accept to the next accept
   always_comb begin
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      alu_op_d     = alu_op_q;
      alu_x_d      = alu_x_q;
      alu_y_d      = alu_y_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_data_d   = rsp_data_q;
      ops_done_d   = ops_done_q;

      if (accept_c) begin
         owner_d = req1_ready;
         if (req1_ready) begin
            alu_op_d = req1_op;
            alu_x_d  = req1_x;
            alu_y_d  = req1_y;
         end else begin
            alu_op_d = req0_op;
            alu_x_d  = req0_x;
            alu_y_d  = req0_y;
         end
      end

      if (state_q == S_CAPTURE) begin
         rsp_data_d  = alu_ans;
         rsp_valid_d = 1'b1;
         rsp_id_d    = owner_q;
      end

      if (rsp_fire_c) begin
         rsp_valid_d  = 1'b0;
         last_grant_d = owner_q;
         ops_done_d   = ops_done_q + CNT_W'(1);
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         alu_op_q     <= '0;
         alu_x_q      <= '0;
         alu_y_q      <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_data_q   <= '0;
         ops_done_q   <= '0;
      end else begin
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         alu_op_q     <= alu_op_d;
         alu_x_q      <= alu_x_d;
         alu_y_q      <= alu_y_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_data_q   <= rsp_data_d;
         ops_done_q   <= ops_done_d;
      end
   end

   assign alu_op    = alu_op_q;
   assign alu_x     = alu_x_q;
   assign alu_y     = alu_y_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign ops_done  = ops_done_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched: scoreboard of tagged results, external ALU modelled here.
module tb_alu_sched;

   localparam int unsigned W = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req0_valid = 1'b0, req1_valid = 1'b0;
   logic [2:0]    req0_op = '0, req1_op = '0;
   logic [W-1:0]  req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
   logic          req0_ready, req1_ready;
   logic          rsp_valid, rsp_id;
   logic [W-1:0]  rsp_data;
   logic          rsp_ready = 1'b0;
   logic [2:0]    alu_op;
   logic [W-1:0]  alu_x, alu_y;
   logic [W-1:0]  alu_ans;
   logic          busy;
   logic [15:0]   ops_done;

   int            n_cmp = 0;
   int            n_err = 0;
   int            n_rsp = 0;
   logic [16:0]   sb_q[$];
   int            grant_q[$];
   logic [15:0]   exp0 = '0, exp1 = '0;
   logic          keep0 = 1'b0, keep1 = 1'b0;
   logic [15:0]   sweep_exp [8];

   always #5 clk = ~clk;

   alu_sched dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_op    (req0_op),
      .req0_x     (req0_x),
      .req0_y     (req0_y),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_op    (req1_op),
      .req1_x     (req1_x),
      .req1_y     (req1_y),
      .req1_ready (req1_ready),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data),
      .rsp_ready  (rsp_ready),
      .alu_op     (alu_op),
      .alu_x      (alu_x),
      .alu_y      (alu_y),
      .alu_ans    (alu_ans),
      .busy       (busy),
      .ops_done   (ops_done)
   );

   // External combinational ALU
   always_comb begin
      case (alu_op)
         3'd0:    alu_ans = alu_x + alu_y;
         3'd1:    alu_ans = alu_x - alu_y;
         3'd2:    alu_ans = alu_x & alu_y;
         3'd3:    alu_ans = alu_x ^ alu_y;
         3'd4:    alu_ans = alu_x | alu_y;
         3'd5:    alu_ans = alu_x + 16'd1;
         3'd6:    alu_ans = alu_x << 1;
         default: alu_ans = alu_x >> 1;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample handshakes, update scoreboard, advance past the edge
   task automatic cycle();
      logic        drop0, drop1, in_reset;
      logic [16:0] e;
      drop0 = 1'b0;
      drop1 = 1'b0;
      #1;
      in_reset = reset;
      chk("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
      if (req0_valid && req0_ready) begin
         sb_q.push_back({1'b0, exp0});
         grant_q.push_back(0);
         drop0 = !keep0;
      end
      if (req1_valid && req1_ready) begin
         sb_q.push_back({1'b1, exp1});
         grant_q.push_back(1);
         drop1 = !keep1;
      end
      if (rsp_valid && rsp_ready) begin
         chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("rsp_id", 32'(rsp_id), 32'(e[16]));
            chk("rsp_data", 32'(rsp_data), 32'(e[15:0]));
         end
         n_rsp++;
      end
      @(posedge clk);
      #1;
      if (in_reset) sb_q.delete();
      if (drop0) req0_valid = 1'b0;
      if (drop1) req1_valid = 1'b0;
   endtask

   task automatic run_rsp(input int k, input int budget);
      int target;
      int n;
      target = n_rsp + k;
      n = 0;
      while (n_rsp < target && n < budget) begin
         cycle();
         n++;
      end
      chk("rsp_timeout", 32'(n_rsp >= target), 32'd1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycle();
      cycle();
      reset = 1'b0;
   endtask

   initial begin
      sweep_exp = '{16'hB595, 16'h95B5, 16'h05A0, 16'hAA55,
                    16'hAFF5, 16'hA5A6, 16'h4B4A, 16'h52D2};

      // Reset: ready held low even with a pending request
      reset = 1'b1;
      req0_valid = 1'b1;
      #1;
      chk("rst_ready0", 32'(req0_ready), 32'd0);
      cycle();
      req0_valid = 1'b0;
      cycle();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("idle_outs", 32'({req0_ready, req1_ready, rsp_valid, rsp_id, busy, alu_op}), 32'd0);
         chk("idle_data", {rsp_data, ops_done}, 32'd0);
         chk("idle_alu", {alu_x, alu_y}, 32'd0);
         cycle();
      end

      // Single add from requester 0, latency and throughput
      rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_op = 3'd0; req0_x = 16'h1234; req0_y = 16'h0F0F; exp0 = 16'h2143;
      #1;
      chk("t2_ready_T", 32'(req0_ready), 32'd1);
      cycle();
      chk("t2_busy_T1", 32'(busy), 32'd1);
      chk("t2_rspv_T1", 32'(rsp_valid), 32'd0);
      cycle();
      chk("t2_rspv_T2", 32'(rsp_valid), 32'd0);
      cycle();
      chk("t2_rspv_T3", 32'(rsp_valid), 32'd1);
      chk("t2_id_T3", 32'(rsp_id), 32'd0);
      chk("t2_data_T3", 32'(rsp_data), 32'h2143);
      chk("t2_alux_T3", 32'(alu_x), 32'h1234);
      req0_valid = 1'b1; req0_op = 3'd0; req0_x = 16'h0001; req0_y = 16'h0001; exp0 = 16'h0002;
      #1;
      chk("t2_noready_T3", 32'(req0_ready), 32'd0);
      cycle();
      chk("t2_ops_T4", 32'(ops_done), 32'd1);
      chk("t2_ready_T4", 32'(req0_ready), 32'd1);
      run_rsp(1, 20);
      chk("t2_ops_end", 32'(ops_done), 32'd2);

      // Continuous contention after reset: 0 first, then alternating
      do_reset();
      grant_q.delete();
      keep0 = 1'b1; keep1 = 1'b1;
      req0_valid = 1'b1; req0_op = 3'd1; req0_x = 16'h0000; req0_y = 16'h0001; exp0 = 16'hFFFF;
      req1_valid = 1'b1; req1_op = 3'd5; req1_x = 16'hFFFF; req1_y = 16'h1234; exp1 = 16'h0000;
      run_rsp(4, 40);
      req0_valid = 1'b0; req1_valid = 1'b0;
      keep0 = 1'b0; keep1 = 1'b0;
      chk("t3_ngrants", 32'(grant_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < grant_q.size()) chk("t3_grant", 32'(grant_q[i]), 32'(i % 2));
      end
      chk("t3_ops", 32'(ops_done), 32'd4);

      // Response stall with requester 0 pending
      grant_q.delete();
      rsp_ready = 1'b0;
      req1_valid = 1'b1; req1_op = 3'd6; req1_x = 16'h8001; req1_y = 16'h0000; exp1 = 16'h0002;
      cycle();
      req0_valid = 1'b1; req0_op = 3'd2; req0_x = 16'hFFFF; req0_y = 16'h00FF; exp0 = 16'h00FF;
      for (int i = 0; i < 10 && !rsp_valid; i++) cycle();
      chk("t4_rsp_wait", 32'(rsp_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t4_hold_data", 32'(rsp_data), 32'h0002);
         chk("t4_hold_vid", 32'({rsp_valid, rsp_id, busy}), 32'b111);
         chk("t4_no_ready", 32'({req0_ready, req1_ready}), 32'd0);
         cycle();
      end
      rsp_ready = 1'b1;
      cycle();
      chk("t4_accept_after", 32'(req0_ready), 32'd1);
      run_rsp(1, 20);
      chk("t4_ngrants", 32'(grant_q.size()), 32'd2);
      if (grant_q.size() == 2) begin
         chk("t4_grant0", 32'(grant_q[0]), 32'd1);
         chk("t4_grant1", 32'(grant_q[1]), 32'd0);
      end

      // Sweep all eight function codes
      for (int op = 0; op < 8; op++) begin
         req0_valid = 1'b1; req0_op = 3'(op); req0_x = 16'hA5A5; req0_y = 16'h0FF0;
         exp0 = sweep_exp[op];
         run_rsp(1, 20);
      end
      chk("t5_ops", 32'(ops_done), 32'd14);

      // Reset during CAPTURE discards the operation
      req0_valid = 1'b1; req0_op = 3'd0; req0_x = 16'h0001; req0_y = 16'h0001; exp0 = 16'h0002;
      cycle();
      cycle();
      chk("t6_capture_busy", 32'({busy, rsp_valid}), 32'b10);
      reset = 1'b1;
      req1_valid = 1'b1; req1_op = 3'd3; req1_x = 16'hF0F0; req1_y = 16'hFFFF; exp1 = 16'h0F0F;
      #1;
      chk("t6_rst_ready1", 32'(req1_ready), 32'd0);
      cycle();
      reset = 1'b0;
      #1;
      chk("t6_post_rspv", 32'(rsp_valid), 32'd0);
      chk("t6_post_ops", 32'(ops_done), 32'd0);
      chk("t6_post_busy", 32'(busy), 32'd0);
      chk("t6_post_zero", {rsp_data, alu_x}, 32'd0);
      chk("t6_post_ready1", 32'(req1_ready), 32'd1);
      cycle();
      chk("t6_rspv_T1", 32'(rsp_valid), 32'd0);
      cycle();
      chk("t6_rspv_T2", 32'(rsp_valid), 32'd0);
      cycle();
      chk("t6_rspv_T3", 32'(rsp_valid), 32'd1);
      chk("t6_ops_pre", 32'(ops_done), 32'd0);
      run_rsp(1, 10);
      chk("t6_ops_end", 32'(ops_done), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
